// File: rtl/name_sequencer_pkg.sv
// rtl/name_sequencer_pkg.sv - shared state encoding and defaults for the name sequencer
package name_sequencer_pkg;

    // 2'd3 is unused and decodes back to ST_IDLE in the top.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] DEF_BLANK_CODE = 4'hF;

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - pushbutton synchroniser, stable-level filter and press pulse
module step_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYC);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_done;

    assign w_done = (r_cnt == CW'(DEB_CYC - 1));

    // Pulse is driven in the cycle before the filtered level commits low,
    // so the consumer sees it on the same edge that the level flips.
    assign press = r_level && !r_sync2 && w_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/name_sequencer.sv
// rtl/name_sequencer.sv - steps a letter-code sequence automatically or by button press
module name_sequencer
    import name_sequencer_pkg::*;
#(
    parameter int               TICK_DIV   = 50_000_000,
    parameter int               DEB_CYC    = 1_000_000,
    parameter int               LEN        = 8,
    parameter logic [LEN*4-1:0] SEQ        = '0,
    parameter logic [3:0]       BLANK_CODE = DEF_BLANK_CODE
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   run_en,
    input  logic                   step_n,
    input  logic                   dir,
    input  logic                   clr,
    output logic [3:0]             code,
    output logic [$clog2(LEN)-1:0] index,
    output logic                   wrap
);

    localparam int             IW   = $clog2(LEN);
    localparam int             PW   = $clog2(TICK_DIV);
    localparam logic [IW-1:0]  LAST = IW'(LEN - 1);

    state_t        r_state;
    logic [IW-1:0] r_index;
    logic [3:0]    r_code;
    logic          r_wrap;
    logic [PW-1:0] r_presc;

    state_t        w_nxt_state;
    logic [IW-1:0] w_nxt_index;
    logic [3:0]    w_nxt_code;
    logic          w_nxt_wrap;
    logic [PW-1:0] w_nxt_presc;
    logic          w_adv;
    logic          w_tick;
    logic          w_press;

    step_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk    (clk),
        .resetn (resetn),
        .btn_n  (step_n),
        .press  (w_press)
    );

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // clr overrides everything; in IDLE run_en beats a simultaneous press.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_index = r_index;
        w_nxt_presc = r_presc;
        w_nxt_wrap  = 1'b0;
        w_adv       = 1'b0;
        if (clr) begin
            w_nxt_state = ST_IDLE;
            w_nxt_index = '0;
            w_nxt_presc = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run_en) begin
                        w_nxt_state = ST_RUN;
                        w_nxt_index = '0;
                        w_nxt_presc = '0;
                    end else if (w_press) begin
                        w_nxt_state = ST_HOLD;
                        w_nxt_index = '0;
                    end
                end
                ST_RUN: begin
                    if (!run_en) begin
                        w_nxt_state = ST_HOLD;
                    end else if (w_tick) begin
                        w_nxt_presc = '0;
                        w_adv       = 1'b1;
                    end else begin
                        w_nxt_presc = r_presc + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (run_en) begin
                        w_nxt_state = ST_RUN;
                        w_nxt_presc = '0;
                    end else if (w_press) begin
                        w_adv = 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_index = '0;
                    w_nxt_presc = '0;
                end
            endcase
        end

        if (w_adv) begin
            if (dir) begin
                if (r_index == '0) begin
                    w_nxt_index = LAST;
                    w_nxt_wrap  = 1'b1;
                end else begin
                    w_nxt_index = r_index - 1'b1;
                end
            end else begin
                if (r_index == LAST) begin
                    w_nxt_index = '0;
                    w_nxt_wrap  = 1'b1;
                end else begin
                    w_nxt_index = r_index + 1'b1;
                end
            end
        end
    end

    assign w_nxt_code = (w_nxt_state == ST_IDLE) ? BLANK_CODE
                                                 : SEQ[{w_nxt_index, 2'b00} +: 4];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_index <= '0;
            r_code  <= BLANK_CODE;
            r_wrap  <= 1'b0;
            r_presc <= '0;
        end else begin
            r_index <= w_nxt_index;
            r_code  <= w_nxt_code;
            r_wrap  <= w_nxt_wrap;
            r_presc <= w_nxt_presc;
        end
    end

    assign code  = r_code;
    assign index = r_index;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_name_sequencer.sv
// tb/tb_name_sequencer.sv - directed vector table plus randomized model check of name_sequencer
module tb_name_sequencer;

    localparam int LEN  = 4;
    localparam int DEB  = 3;
    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       run_en;
    logic       step_n;
    logic       dir;
    logic       clr;
    logic [3:0] code;
    logic [1:0] index;
    logic       wrap;

    always #5 clk = ~clk;

    name_sequencer #(
        .TICK_DIV   (TDIV),
        .DEB_CYC    (DEB),
        .LEN        (LEN),
        .SEQ        (16'h3210),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .run_en (run_en),
        .step_n (step_n),
        .dir    (dir),
        .clr    (clr),
        .code   (code),
        .index  (index),
        .wrap   (wrap)
    );

    typedef struct {
        logic       run_en;
        logic       dir;
        logic       clr;
        logic       step_n;
        logic [3:0] code;
        logic [1:0] index;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic r, input logic d, input logic c, input logic s,
                       input logic [3:0] ec, input logic [1:0] ei, input logic ew, input int n);
        vec_t v;
        v.run_en = r; v.dir = d; v.clr = c; v.step_n = s;
        v.code = ec; v.index = ei; v.wrap = ew;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: behaviour described in terms of the sequencing rules,
    // with the debounce expressed as a sliding window over raw button samples.
    typedef enum {M_IDLE, M_RUN, M_HOLD} mstate_t;
    mstate_t    m_state;
    int         m_idx;
    bit         m_wrap;
    int         m_age;
    bit         m_lvl;
    bit         raw_q[$];
    logic [3:0] seq_tab [LEN] = '{4'h0, 4'h1, 4'h2, 4'h3};

    task automatic model_reset();
        m_state = M_IDLE; m_idx = 0; m_wrap = 0; m_age = 0; m_lvl = 1;
        raw_q.delete();
        for (int i = 0; i < DEB + 2; i++) raw_q.push_back(1'b1);
    endtask

    task automatic model_advance(input bit d);
        m_wrap = d ? (m_idx == 0) : (m_idx == LEN - 1);
        m_idx  = d ? (m_idx + LEN - 1) % LEN : (m_idx + 1) % LEN;
    endtask

    task automatic model_edge(input bit r, input bit d, input bit c, input bit s);
        bit press;
        bit all_diff;
        raw_q.push_back(s);
        if (raw_q.size() > 16) void'(raw_q.pop_front());
        all_diff = 1;
        for (int j = 0; j < DEB; j++)
            if (raw_q[raw_q.size() - 3 - j] == m_lvl) all_diff = 0;
        press = 0;
        if (all_diff) begin
            m_lvl = !m_lvl;
            press = (m_lvl == 0);
        end
        m_wrap = 0;
        if (c) begin
            m_state = M_IDLE; m_idx = 0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (r) begin
                        m_state = M_RUN; m_idx = 0; m_age = 0;
                    end else if (press) begin
                        m_state = M_HOLD; m_idx = 0;
                    end
                end
                M_RUN: begin
                    if (!r) m_state = M_HOLD;
                    else begin
                        m_age++;
                        if (m_age % TDIV == 0) model_advance(d);
                    end
                end
                default: begin
                    if (r) begin
                        m_state = M_RUN; m_age = 0;
                    end else if (press) model_advance(d);
                end
            endcase
        end
    endtask

    initial begin
        bit step_cur;
        int hold_left;
        resetn = 1'b0; run_en = 1'b0; dir = 1'b0; clr = 1'b0; step_n = 1'b1;

        // auto run forward with wrap
        add(1,0,0,1, 4'h0,0,0, 4);
        add(1,0,0,1, 4'h1,1,0, 4);
        add(1,0,0,1, 4'h2,2,0, 4);
        add(1,0,0,1, 4'h3,3,0, 4);
        add(1,0,0,1, 4'h0,0,1, 1);
        add(1,0,0,1, 4'h0,0,0, 3);
        // clr beats run_en and a tick on the same edge
        add(1,0,1,1, 4'hF,0,0, 1);
        // press and run_en land together in IDLE
        add(0,0,0,0, 4'hF,0,0, 4);
        add(1,0,0,0, 4'h0,0,0, 4);
        add(1,0,0,0, 4'h1,1,0, 4);
        add(1,0,0,0, 4'h2,2,0, 1);
        // pause at index 2, release button, resume
        add(0,0,0,0, 4'h2,2,0, 1);
        add(0,0,0,1, 4'h2,2,0, 8);
        add(1,0,0,1, 4'h2,2,0, 4);
        add(1,0,0,1, 4'h3,3,0, 4);
        add(1,0,0,1, 4'h0,0,1, 1);
        add(0,0,0,1, 4'h0,0,0, 1);
        // reverse from index 0 in HOLD
        add(0,1,0,0, 4'h0,0,0, 4);
        add(0,1,0,0, 4'h3,3,1, 1);
        add(0,1,0,0, 4'h3,3,0, 1);
        add(0,1,0,1, 4'h3,3,0, 6);
        add(0,1,0,0, 4'h3,3,0, 4);
        add(0,1,0,0, 4'h2,2,0, 1);
        add(0,0,0,1, 4'h2,2,0, 6);
        // bouncy press then bouncy release
        for (int i = 0; i < 10; i++) add(0,0,0,(i % 2 == 1), 4'h2,2,0, 1);
        add(0,0,0,0, 4'h2,2,0, 4);
        add(0,0,0,0, 4'h3,3,0, 16);
        for (int i = 0; i < 10; i++) add(0,0,0,(i % 2 == 0), 4'h3,3,0, 1);
        add(0,0,0,1, 4'h3,3,0, 10);
        // run to index 2 for the async reset case
        add(1,0,0,1, 4'h3,3,0, 4);
        add(1,0,0,1, 4'h0,0,1, 1);
        add(1,0,0,1, 4'h0,0,0, 3);
        add(1,0,0,1, 4'h1,1,0, 4);
        add(1,0,0,1, 4'h2,2,0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("reset code", code, 4'hF);
        check("reset index", index, 0);
        check("reset wrap", wrap, 0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_en = vecs[i].run_en; dir = vecs[i].dir;
            clr = vecs[i].clr; step_n = vecs[i].step_n;
            @(posedge clk);
            #1;
            check($sformatf("row%0d code", i), code, vecs[i].code);
            check($sformatf("row%0d index", i), index, vecs[i].index);
            check($sformatf("row%0d wrap", i), wrap, vecs[i].wrap);
        end

        // asynchronous reset mid-RUN at index 2
        #2;
        resetn = 1'b0;
        #1;
        check("async reset code", code, 4'hF);
        check("async reset index", index, 0);
        check("async reset wrap", wrap, 0);
        @(posedge clk);
        #1;
        run_en = 1'b0; dir = 1'b0; clr = 1'b0; step_n = 1'b1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset%0d code", i), code, 4'hF);
            check($sformatf("post-reset%0d index", i), index, 0);
        end

        model_reset();
        m_lvl = 1;
        for (int i = 0; i < DEB + 2; i++) model_edge(0, 0, 0, 1);
        model_reset();
        step_cur = 1'b1;
        hold_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(15) == 0) run_en = ~run_en;
            if ($urandom_range(7) == 0) dir = ~dir;
            clr = ($urandom_range(59) == 0);
            if (hold_left == 0) begin
                step_cur = ~step_cur;
                hold_left = $urandom_range(1, 8);
            end else begin
                hold_left--;
            end
            step_n = step_cur;
            @(posedge clk);
            #1;
            model_edge(run_en, dir, clr, step_cur);
            check($sformatf("rand%0d code", cyc), code,
                  (m_state == M_IDLE) ? 4'hF : seq_tab[m_idx]);
            check($sformatf("rand%0d index", cyc), index, m_idx);
            check($sformatf("rand%0d wrap", cyc), wrap, m_wrap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
